// File: rtl/lif_mon_pkg.sv
// lif_mon_pkg: shared types and helpers for the LIF spike monitor.
//   mon_state_e     : monitor FSM state (IDLE, RUN)
//   DEF_*           : default widths for the monitor parameters
//   STATE_W         : width of the neuron membrane state bus
//   sat_inc()       : saturating conditional increment (32-bit container)
package lif_mon_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } mon_state_e;

    localparam int unsigned DEF_WINDOW_LOG2 = 8;
    localparam int unsigned DEF_CNT_W       = 8;
    localparam int unsigned DEF_ISI_W       = 8;
    localparam int unsigned STATE_W         = 8;

    // Returns val+1 when inc is set and val has not reached max_val, else val.
    // Callers zero-extend narrower operands and truncate the result back.
    function automatic logic [31:0] sat_inc(input logic [31:0] val,
                                            input logic [31:0] max_val,
                                            input logic        inc);
        logic [31:0] res;
        res = val;
        if (inc && (val != max_val)) begin
            res = val + 32'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/lif_isi_timer.sv
// lif_isi_timer: inter-spike interval measurement for the LIF spike monitor.
// Only instantiated when SPIKE_ISI_EN is defined.
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   ena        in   timer enable; low clears the interval counter and the armed flag
//   spike_evt  in   one-cycle spike rising-edge event
//   isi        out  cycles between the last two spike events (saturating, held)
//   isi_valid  out  one-cycle pulse when isi is updated
module lif_isi_timer
    import lif_mon_pkg::*;
#(
    parameter int unsigned ISI_W = DEF_ISI_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             spike_evt,
    output logic [ISI_W-1:0] isi,
    output logic             isi_valid
);

    localparam logic [ISI_W-1:0] ISI_MAX = '1;

    logic [ISI_W-1:0] isi_cnt_q, isi_cnt_d;
    logic             armed_q, armed_d;
    logic [ISI_W-1:0] isi_q, isi_d;
    logic             isi_valid_q, isi_valid_d;

    always_comb begin
        isi_cnt_d   = isi_cnt_q;
        armed_d     = armed_q;
        isi_d       = isi_q;
        isi_valid_d = 1'b0;
        if (!ena) begin
            isi_cnt_d = '0;
            armed_d   = 1'b0;
        end else if (spike_evt) begin
            // The first event only arms; later events report the elapsed
            // count including the event cycle itself.
            if (armed_q) begin
                isi_d       = ISI_W'(sat_inc(32'(isi_cnt_q), 32'(ISI_MAX), 1'b1));
                isi_valid_d = 1'b1;
            end
            armed_d   = 1'b1;
            isi_cnt_d = '0;
        end else begin
            isi_cnt_d = ISI_W'(sat_inc(32'(isi_cnt_q), 32'(ISI_MAX), 1'b1));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            isi_cnt_q   <= '0;
            armed_q     <= 1'b0;
            isi_q       <= '0;
            isi_valid_q <= 1'b0;
        end else begin
            isi_cnt_q   <= isi_cnt_d;
            armed_q     <= armed_d;
            isi_q       <= isi_d;
            isi_valid_q <= isi_valid_d;
        end
    end

    assign isi       = isi_q;
    assign isi_valid = isi_valid_q;

endmodule

// File: rtl/lif_spike_monitor.sv
// lif_spike_monitor: firing-rate / peak-state monitor for a LIF neuron.
// Counts spike rising edges and tracks the peak membrane state over
// back-to-back windows of 2**WINDOW_LOG2 cycles. Optional inter-spike
// interval measurement is built when the macro SPIKE_ISI_EN is defined;
// otherwise isi and isi_valid are tied to 0.
// Ports:
//   clk         in   rising-edge clock
//   rst_n       in   asynchronous active-low reset
//   ena         in   monitor enable; low drops the partial window
//   spike       in   neuron spike level (one event per rising edge)
//   state       in   neuron membrane state, unsigned
//   rate        out  spike count of the last completed window (saturating)
//   rate_sat    out  count saturated in the last completed window
//   peak_state  out  maximum state sampled in the last completed window
//   rate_valid  out  one-cycle pulse when rate/rate_sat/peak_state update
//   isi         out  cycles between the last two spike edges
//   isi_valid   out  one-cycle pulse when isi updates
module lif_spike_monitor
    import lif_mon_pkg::*;
#(
    parameter int unsigned WINDOW_LOG2 = DEF_WINDOW_LOG2,
    parameter int unsigned CNT_W       = DEF_CNT_W,
    parameter int unsigned ISI_W       = DEF_ISI_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ena,
    input  logic               spike,
    input  logic [STATE_W-1:0] state,
    output logic [CNT_W-1:0]   rate,
    output logic               rate_sat,
    output logic [STATE_W-1:0] peak_state,
    output logic               rate_valid,
    output logic [ISI_W-1:0]   isi,
    output logic               isi_valid
);

    localparam logic [WINDOW_LOG2-1:0] WIN_LAST = '1;
    localparam logic [CNT_W-1:0]       CNT_MAX  = '1;

    mon_state_e             fsm_q, fsm_d;
    logic                   spike_q;
    logic                   spike_evt;
    logic [WINDOW_LOG2-1:0] win_cnt_q, win_cnt_d;
    logic [CNT_W-1:0]       acc_cnt_q, acc_cnt_d;
    logic                   acc_sat_q, acc_sat_d;
    logic [STATE_W-1:0]     acc_peak_q, acc_peak_d;
    logic [CNT_W-1:0]       rate_q, rate_d;
    logic                   rate_sat_q, rate_sat_d;
    logic [STATE_W-1:0]     peak_q, peak_d;
    logic                   rate_valid_q, rate_valid_d;

    // Accumulator values including the current cycle's event and state.
    logic [CNT_W-1:0]       cnt_next;
    logic                   sat_next;
    logic [STATE_W-1:0]     peak_next;

    assign spike_evt = spike & ~spike_q;

    always_comb begin
        cnt_next  = CNT_W'(sat_inc(32'(acc_cnt_q), 32'(CNT_MAX), spike_evt));
        sat_next  = acc_sat_q | (spike_evt & (acc_cnt_q == CNT_MAX));
        peak_next = (state > acc_peak_q) ? state : acc_peak_q;
    end

    always_comb begin
        fsm_d        = fsm_q;
        win_cnt_d    = win_cnt_q;
        acc_cnt_d    = acc_cnt_q;
        acc_sat_d    = acc_sat_q;
        acc_peak_d   = acc_peak_q;
        rate_d       = rate_q;
        rate_sat_d   = rate_sat_q;
        peak_d       = peak_q;
        rate_valid_d = 1'b0;
        case (fsm_q)
            IDLE: begin
                win_cnt_d  = '0;
                acc_cnt_d  = '0;
                acc_sat_d  = 1'b0;
                acc_peak_d = '0;
                if (ena) begin
                    fsm_d = RUN;
                end
            end
            RUN: begin
                if (!ena) begin
                    // Dropping enable discards the partial window, even on
                    // what would have been its closing cycle.
                    fsm_d      = IDLE;
                    win_cnt_d  = '0;
                    acc_cnt_d  = '0;
                    acc_sat_d  = 1'b0;
                    acc_peak_d = '0;
                end else if (win_cnt_q == WIN_LAST) begin
                    rate_d       = cnt_next;
                    rate_sat_d   = sat_next;
                    peak_d       = peak_next;
                    rate_valid_d = 1'b1;
                    win_cnt_d    = '0;
                    acc_cnt_d    = '0;
                    acc_sat_d    = 1'b0;
                    acc_peak_d   = '0;
                end else begin
                    win_cnt_d  = win_cnt_q + 1'b1;
                    acc_cnt_d  = cnt_next;
                    acc_sat_d  = sat_next;
                    acc_peak_d = peak_next;
                end
            end
            default: begin
                fsm_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q        <= IDLE;
            spike_q      <= 1'b0;
            win_cnt_q    <= '0;
            acc_cnt_q    <= '0;
            acc_sat_q    <= 1'b0;
            acc_peak_q   <= '0;
            rate_q       <= '0;
            rate_sat_q   <= 1'b0;
            peak_q       <= '0;
            rate_valid_q <= 1'b0;
        end else begin
            fsm_q        <= fsm_d;
            spike_q      <= spike;
            win_cnt_q    <= win_cnt_d;
            acc_cnt_q    <= acc_cnt_d;
            acc_sat_q    <= acc_sat_d;
            acc_peak_q   <= acc_peak_d;
            rate_q       <= rate_d;
            rate_sat_q   <= rate_sat_d;
            peak_q       <= peak_d;
            rate_valid_q <= rate_valid_d;
        end
    end

    assign rate       = rate_q;
    assign rate_sat   = rate_sat_q;
    assign peak_state = peak_q;
    assign rate_valid = rate_valid_q;

`ifdef SPIKE_ISI_EN
    lif_isi_timer #(
        .ISI_W(ISI_W)
    ) u_isi_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .spike_evt (spike_evt),
        .isi       (isi),
        .isi_valid (isi_valid)
    );
`else
    assign isi       = '0;
    assign isi_valid = 1'b0;
`endif

endmodule
